encoder_fifo_tx: RTL and testbench



---
 rtl/lpc_tx_pkg.sv | 20 ++
 rtl/tx_sample_fifo.sv | 63 ++++++
 rtl/encoder_fifo_tx.sv | 153 +++++++++++++++
 tb/tb_encoder_fifo_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_tx_pkg.sv
// Shared types and constants for the LPC transmit path (encoder FIFO + beat packer).
package lpc_tx_pkg;

   localparam int unsigned DATA_WIDTH_DFLT       = 16;
   localparam int unsigned SAMPLES_PER_BEAT_DFLT = 5;
   localparam int unsigned BEAT_WIDTH            = DATA_WIDTH_DFLT * SAMPLES_PER_BEAT_DFLT;

   // A single-lane beat still needs a one-bit counter.
   function automatic int unsigned lane_cnt_width(input int unsigned spb);
      return (spb > 1) ? $clog2(spb) : 1;
   endfunction

   localparam int unsigned LANE_CNT_WIDTH = lane_cnt_width(SAMPLES_PER_BEAT_DFLT);

   typedef enum logic {
      StFill = 1'b0,
      StSend = 1'b1
   } tx_state_e;

endpackage

// File: rtl/tx_sample_fifo.sv
// First-word-fall-through synchronous FIFO holding {last, sample} entries for the packer.
module tx_sample_fifo #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned WIDTH = 17
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             overflow_o
);

   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam int unsigned PtrW  = AddrW + 1;

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push;
   logic             pop;

   // Extra pointer MSB distinguishes full from empty when the address bits match.
   assign full_o     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                       (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign push       = wr_en_i && !full_o;
   assign pop        = rd_en_i && !empty_o;
   assign overflow_o = wr_en_i && full_o;
   assign rd_data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AddrW-1:0]] = wr_data_i;
         wr_ptr_d                   = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/encoder_fifo_tx.sv
// Sample FIFO plus packer: groups samples into multi-lane AXI-Stream beats split at packet ends.
// Optional TKEEP output is enabled by defining ENCODER_FIFO_TX_TKEEP_EN.
module encoder_fifo_tx
   import lpc_tx_pkg::*;
#(
   parameter int unsigned DEPTH            = 128,
   parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DFLT,
   parameter int unsigned SAMPLES_PER_BEAT = SAMPLES_PER_BEAT_DFLT
) (
   input  logic                                   ACLK,
   input  logic                                   ARESET,
   input  logic                                   EN,
   input  logic                                   WR_EN,
   input  logic [DATA_WIDTH-1:0]                  WR_DATA,
   input  logic                                   WR_LAST,
   output logic                                   FIFO_FULL,
   output logic                                   OVERFLOW,
   output logic [DATA_WIDTH*SAMPLES_PER_BEAT-1:0] TDATA,
   output logic                                   TVALID,
   input  logic                                   TREADY,
   output logic                                   TUSER,
   output logic                                   TLAST
`ifdef ENCODER_FIFO_TX_TKEEP_EN
   ,
   output logic [SAMPLES_PER_BEAT-1:0]            TKEEP
`endif
);

   localparam int unsigned BeatW = DATA_WIDTH * SAMPLES_PER_BEAT;
   localparam int unsigned CntW  = lane_cnt_width(SAMPLES_PER_BEAT);

   logic                  fifo_empty;
   logic                  fifo_ovf;
   logic                  fifo_pop;
   logic [DATA_WIDTH:0]   fifo_rd;

   tx_state_e             state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [SAMPLES_PER_BEAT-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d;
   logic [BeatW-1:0]      tdata_q, tdata_d;
   logic                  tuser_q, tuser_d;
   logic                  tlast_q, tlast_d;
   logic                  first_q, first_d;
   logic                  overflow_q, overflow_d;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
   logic [SAMPLES_PER_BEAT-1:0] tkeep_q, tkeep_d;
`endif

   tx_sample_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk_i      (ACLK),
      .rst_i      (ARESET),
      .wr_en_i    (WR_EN),
      .wr_data_i  ({WR_LAST, WR_DATA}),
      .rd_en_i    (fifo_pop),
      .rd_data_o  (fifo_rd),
      .full_o     (FIFO_FULL),
      .empty_o    (fifo_empty),
      .overflow_o (fifo_ovf)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lanes_d    = lanes_q;
      tdata_d    = tdata_q;
      tuser_d    = tuser_q;
      tlast_d    = tlast_q;
      first_d    = first_q;
      overflow_d = overflow_q | fifo_ovf;
      fifo_pop   = 1'b0;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
      tkeep_d    = tkeep_q;
`endif

      unique case (state_q)
         StFill: begin
            if (EN && !fifo_empty) begin
               fifo_pop = 1'b1;
               for (int unsigned i = 0; i < SAMPLES_PER_BEAT; i++) begin
                  if (CntW'(i) == cnt_q) begin
                     lanes_d[i] = fifo_rd[DATA_WIDTH-1:0];
                  end
               end
               cnt_d = cnt_q + CntW'(1);
               // Beat closes on packet end or when the last lane is filled.
               if (fifo_rd[DATA_WIDTH] || (cnt_q == CntW'(SAMPLES_PER_BEAT - 1))) begin
                  state_d = StSend;
                  tdata_d = lanes_d;
                  tlast_d = fifo_rd[DATA_WIDTH];
                  tuser_d = first_q;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
                  for (int unsigned i = 0; i < SAMPLES_PER_BEAT; i++) begin
                     tkeep_d[i] = (CntW'(i) <= cnt_q);
                  end
`endif
               end
            end
         end
         StSend: begin
            if (TREADY) begin
               state_d = StFill;
               cnt_d   = '0;
               lanes_d = '0;
               first_d = tlast_q;
            end
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= StFill;
         cnt_q      <= '0;
         lanes_q    <= '0;
         tdata_q    <= '0;
         tuser_q    <= 1'b0;
         tlast_q    <= 1'b0;
         first_q    <= 1'b1;
         overflow_q <= 1'b0;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
         tkeep_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lanes_q    <= lanes_d;
         tdata_q    <= tdata_d;
         tuser_q    <= tuser_d;
         tlast_q    <= tlast_d;
         first_q    <= first_d;
         overflow_q <= overflow_d;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
         tkeep_q    <= tkeep_d;
`endif
      end
   end

   assign TVALID   = (state_q == StSend);
   assign TDATA    = tdata_q;
   assign TUSER    = tuser_q;
   assign TLAST    = tlast_q;
   assign OVERFLOW = overflow_q;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
   assign TKEEP    = tkeep_q;
`endif

endmodule

// File: tb/tb_encoder_fifo_tx.sv
// Bench for encoder_fifo_tx: directed and randomized traffic against a sample-queue packet model.
module tb_encoder_fifo_tx;
   import lpc_tx_pkg::*;

   localparam int unsigned DEPTH = 128;
   localparam int unsigned SPB   = 5;

   typedef struct {
      logic [BEAT_WIDTH-1:0] data;
      logic                  user;
      logic                  last;
      logic [SPB-1:0]        keep;
   } beat_t;

   logic                  ACLK = 1'b0;
   logic                  ARESET = 1'b1;
   logic                  EN = 1'b0;
   logic                  WR_EN = 1'b0;
   logic [15:0]           WR_DATA = '0;
   logic                  WR_LAST = 1'b0;
   logic                  TREADY = 1'b0;
   logic                  FIFO_FULL;
   logic                  OVERFLOW;
   logic [BEAT_WIDTH-1:0] TDATA;
   logic                  TVALID;
   logic                  TUSER;
   logic                  TLAST;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
   logic [SPB-1:0]        TKEEP;
`endif

   int vectors = 0;
   int miscompares = 0;

   beat_t obs_q[$];
   beat_t exp_q[$];

   logic [BEAT_WIDTH-1:0] m_lanes = '0;
   int                    m_cnt = 0;
   bit                    m_first = 1'b1;

   encoder_fifo_tx #(
      .DEPTH            (DEPTH),
      .DATA_WIDTH       (16),
      .SAMPLES_PER_BEAT (SPB)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .EN        (EN),
      .WR_EN     (WR_EN),
      .WR_DATA   (WR_DATA),
      .WR_LAST   (WR_LAST),
      .FIFO_FULL (FIFO_FULL),
      .OVERFLOW  (OVERFLOW),
      .TDATA     (TDATA),
      .TVALID    (TVALID),
      .TREADY    (TREADY),
      .TUSER     (TUSER),
      .TLAST     (TLAST)
`ifdef ENCODER_FIFO_TX_TKEEP_EN
      ,
      .TKEEP     (TKEEP)
`endif
   );

   always #5 ACLK = ~ACLK;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Inputs change 1 time unit after posedge, so a negedge sample sees the handshake.
   always @(negedge ACLK) begin : monitor
      beat_t b;
      if (ARESET === 1'b0 && TVALID === 1'b1 && TREADY === 1'b1) begin
         b.data = TDATA;
         b.user = TUSER;
         b.last = TLAST;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
         b.keep = TKEEP;
`else
         b.keep = '0;
`endif
         obs_q.push_back(b);
      end
   end

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [BEAT_WIDTH-1:0] obs,
                        input logic [BEAT_WIDTH-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packet model: samples fill lanes in order; a beat closes on last or a full lane set.
   task automatic model_push(input logic [15:0] d, input bit last);
      beat_t b;
      m_lanes[16*m_cnt +: 16] = d;
      m_cnt++;
      if (last || m_cnt == SPB) begin
         b.data = m_lanes;
         b.user = m_first;
         b.last = last;
`ifdef ENCODER_FIFO_TX_TKEEP_EN
         b.keep = SPB'((1 << m_cnt) - 1);
`else
         b.keep = '0;
`endif
         exp_q.push_back(b);
         m_first = last;
         m_lanes = '0;
         m_cnt   = 0;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_lanes = '0;
      m_cnt   = 0;
      m_first = 1'b1;
   endtask

   task automatic write(input logic [15:0] d, input bit last);
      WR_EN   = 1'b1;
      WR_DATA = d;
      WR_LAST = last;
      model_push(d, last);
      step();
      WR_EN   = 1'b0;
      WR_LAST = 1'b0;
   endtask

   task automatic compare_beats(input string tag);
      int n;
      check({tag, "_beats"}, BEAT_WIDTH'(obs_q.size()), BEAT_WIDTH'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
         check({tag, "_user"}, BEAT_WIDTH'(obs_q[i].user), BEAT_WIDTH'(exp_q[i].user));
         check({tag, "_last"}, BEAT_WIDTH'(obs_q[i].last), BEAT_WIDTH'(exp_q[i].last));
`ifdef ENCODER_FIFO_TX_TKEEP_EN
         check({tag, "_keep"}, BEAT_WIDTH'(obs_q[i].keep), BEAT_WIDTH'(exp_q[i].keep));
`endif
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic drain(input string tag);
      int n;
      EN     = 1'b1;
      TREADY = 1'b1;
      n      = 0;
      while (obs_q.size() < exp_q.size() && n < 2000) begin
         step();
         n++;
      end
      repeat (10) step();
      compare_beats(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, BEAT_WIDTH'(TVALID), '0);
      check({tag, "_tdata"}, TDATA, '0);
      check({tag, "_tuser"}, BEAT_WIDTH'(TUSER), '0);
      check({tag, "_tlast"}, BEAT_WIDTH'(TLAST), '0);
      check({tag, "_full"}, BEAT_WIDTH'(FIFO_FULL), '0);
      check({tag, "_ovf"}, BEAT_WIDTH'(OVERFLOW), '0);
   endtask

   initial begin : stimulus
      logic [BEAT_WIDTH-1:0] hold_data;
      logic                  hold_user;
      logic                  hold_last;
      logic [BEAT_WIDTH-1:0] t1_exp;
      int                    n;
      int                    nw;
      bit                    pend;
      bit                    lst;

      // Reset
      ARESET = 1'b1;
      step();
      step();
      check_reset_outputs("rst");
      ARESET = 1'b0;
      model_reset();

      // Five samples, one full beat ending the packet; TVALID rises one cycle after last pop
      EN     = 1'b1;
      TREADY = 1'b1;
      for (int i = 1; i <= 5; i++) write(16'(i), i == 5);
      check("t1_tvalid_early", BEAT_WIDTH'(TVALID), '0);
      step();
      t1_exp = 80'h0005_0004_0003_0002_0001;
      check("t1_tvalid", BEAT_WIDTH'(TVALID), BEAT_WIDTH'(1));
      check("t1_tdata", TDATA, t1_exp);
      check("t1_tuser", BEAT_WIDTH'(TUSER), BEAT_WIDTH'(1));
      check("t1_tlast", BEAT_WIDTH'(TLAST), BEAT_WIDTH'(1));
      drain("t1");

      // Seven-sample packet: full beat then a two-lane short beat
      for (int i = 0; i < 7; i++) write(16'(16'h0010 + i), i == 6);
      drain("t2");

      // Backpressure: beat held stable while TREADY low, FIFO keeps accepting
      TREADY = 1'b0;
      for (int i = 0; i < 5; i++) write(16'($urandom), i == 4);
      n = 0;
      while (TVALID !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("bp_tvalid", BEAT_WIDTH'(TVALID), BEAT_WIDTH'(1));
      hold_data = TDATA;
      hold_user = TUSER;
      hold_last = TLAST;
      for (int k = 0; k < 10; k++) begin
         if (k < 3) write(16'($urandom), k == 2);
         else step();
         check("bp_hold_valid", BEAT_WIDTH'(TVALID), BEAT_WIDTH'(1));
         check("bp_hold_data", TDATA, hold_data);
         check("bp_hold_user", BEAT_WIDTH'(TUSER), BEAT_WIDTH'(hold_user));
         check("bp_hold_last", BEAT_WIDTH'(TLAST), BEAT_WIDTH'(hold_last));
      end
      drain("bp");

      // Fill to DEPTH with the packer stalled, then one dropped write
      EN = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check("ovf_not_full", BEAT_WIDTH'(FIFO_FULL), '0);
         lst = (i == DEPTH - 1) || ($urandom_range(0, 7) == 0);
         write(16'($urandom), lst);
      end
      check("ovf_full", BEAT_WIDTH'(FIFO_FULL), BEAT_WIDTH'(1));
      check("ovf_pre", BEAT_WIDTH'(OVERFLOW), '0);
      WR_EN   = 1'b1;
      WR_DATA = 16'hDEAD;
      WR_LAST = 1'b1;
      step();
      WR_EN   = 1'b0;
      WR_LAST = 1'b0;
      check("ovf_sticky", BEAT_WIDTH'(OVERFLOW), BEAT_WIDTH'(1));
      check("ovf_full2", BEAT_WIDTH'(FIFO_FULL), BEAT_WIDTH'(1));
      drain("ovf");
      check("ovf_held", BEAT_WIDTH'(OVERFLOW), BEAT_WIDTH'(1));

      // EN stall after two pops keeps lane order
      EN = 1'b0;
      for (int i = 0; i < 5; i++) write(16'($urandom), i == 4);
      EN = 1'b1;
      step();
      step();
      EN = 1'b0;
      repeat (4) step();
      check("stall_tvalid", BEAT_WIDTH'(TVALID), '0);
      EN = 1'b1;
      step();
      step();
      check("stall_tvalid_pre", BEAT_WIDTH'(TVALID), '0);
      step();
      check("stall_tvalid_rise", BEAT_WIDTH'(TVALID), BEAT_WIDTH'(1));
      drain("stall");

      // Randomized traffic; write count stays below DEPTH so nothing is dropped
      nw   = 0;
      pend = 1'b0;
      for (int c = 0; c < 300; c++) begin
         EN     = ($urandom_range(0, 9) < 8);
         TREADY = ($urandom_range(0, 9) < 7);
         if (nw < 100 && $urandom_range(0, 1) == 1) begin
            lst = ($urandom_range(0, 5) == 0);
            write(16'($urandom), lst);
            nw++;
            pend = !lst;
         end else begin
            step();
         end
      end
      if (pend) write(16'($urandom), 1'b1);
      drain("rand");

      // Reset mid-packet discards FIFO contents and partial lanes
      EN     = 1'b0;
      TREADY = 1'b1;
      for (int i = 0; i < 5; i++) write(16'($urandom), 1'b0);
      EN = 1'b1;
      step();
      step();
      EN     = 1'b0;
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      check_reset_outputs("mid_rst");
      model_reset();
      obs_q.delete();
      EN = 1'b1;
      repeat (10) step();
      check("mid_rst_silent", BEAT_WIDTH'(obs_q.size()), '0);
      for (int i = 0; i < 7; i++) write(16'($urandom), i == 6);
      drain("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
